neuron_mac_scheduler: RTL and testbench
=======================================

NEURON_MAC_SCHEDULER -- requirements
Module: neuron_mac_scheduler

Interface
REQ-001 The block SHALL have parameter N_PIX, default 784, giving pixels per image and MAC terms per neuron (legal range 2..1023).
REQ-002 The block SHALL have parameter N_NEURON, default 10, giving the number of output neurons (weight rows).
REQ-003 The block SHALL have parameter MULT_LAT, default 1, giving the attached multiplier's cycles from operand to product (legal range 1..4).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 GlobalReset  in  1  asynchronous, active-high reset.
REQ-006 Start  in  1  request one neuron dot product; sampled each rising edge.
REQ-007 NeuronSel  in  4  weight row index; captured when Start is accepted.
REQ-008 PixAddr  out  10  pixel memory read address.
REQ-009 WeightAddr  out  14  weight memory read address, equal to NeuronSel*N_PIX + index.
REQ-010 PixelIn  in  10  unsigned pixel, valid one cycle after PixAddr (synchronous memory).
REQ-011 WeightIn  in  19  signed two's-complement weight, valid one cycle after WeightAddr.
REQ-012 WeightPort  out  19  registered weight operand to the multiplier.
REQ-013 PixelPort  out  10  registered pixel operand to the multiplier.
REQ-014 ProductIn  in  26  signed product returned from the multiplier, MULT_LAT cycles after the operands.
REQ-015 AccOut  out  36  signed accumulated dot product.
REQ-016 Busy  out  1  high while a dot product is in progress.
REQ-017 Done  out  1  single-cycle pulse marking the final AccOut value.

Function
REQ-018 The FSM SHALL have three states:
- IDLE: waits for an accepted Start, then goes to ISSUE.
- ISSUE: index counts 0..N_PIX-1, one per cycle; after the last index it goes to DRAIN.
- DRAIN: waits for the valid pipeline to empty, then returns to IDLE.
REQ-019 Start SHALL be accepted only in IDLE and only with NeuronSel < N_NEURON; otherwise it is ignored with no side effects.
REQ-020 At the accept edge E0 the block SHALL clear AccOut to 0, capture NeuronSel and set Busy.
REQ-021 Index k SHALL be presented on PixAddr/WeightAddr during the cycle after edge E(k).
REQ-022 Operands for index k SHALL load into WeightPort/PixelPort at edge E(k+2).
REQ-023 ProductIn for index k SHALL be added, sign-extended to 36 bits, into AccOut at edge E(k+2+MULT_LAT).
REQ-024 Products SHALL be accumulated only when the valid shift-register tap is set; no product is dropped or double-counted.
REQ-025 WeightPort and PixelPort SHALL be driven to 0 whenever their pipeline stage is invalid.
REQ-026 At edge E(N_PIX+1+MULT_LAT), when the final term is added, Busy SHALL fall and Done SHALL rise for exactly one cycle.
REQ-027 AccOut SHALL hold the final sum from the Done edge until the next accepted Start.
REQ-028 A Start present during the Done cycle SHALL be accepted, giving back-to-back operation with no idle cycle.
REQ-029 Start, NeuronSel changes and X on ProductIn while in IDLE SHALL have no effect on AccOut.
REQ-030 NeuronSel changes during ISSUE or DRAIN SHALL not affect WeightAddr.
REQ-031 The 36-bit accumulator SHALL not overflow for N_PIX <= 1023; no saturation logic is required.
REQ-032 PixAddr and WeightAddr SHALL return to 0 in IDLE.

Reset
REQ-033 Asserting GlobalReset SHALL immediately force IDLE and clear the index, valid pipeline, WeightPort, PixelPort, AccOut, Busy, Done, PixAddr and WeightAddr to 0.
REQ-034 A reset asserted mid-operation SHALL abort the dot product with no Done pulse.
REQ-035 Operation SHALL resume only on a Start accepted after GlobalReset is released.

Verification (N_PIX=4, MULT_LAT=1, memory and multiplier models in the bench)
REQ-036 Basic sum: pixels 1,2,3,4, weights 10,20,30,40, NeuronSel=0 -> PixAddr 0..3 on the four cycles after E0, then Done at E6 with AccOut=300 held afterwards.
REQ-037 Signed weights: weight -5 (19'h7FFFB) at all indices, pixel 8 at all indices -> AccOut=-160 (36'hFFFFFFF60) at Done.
REQ-038 Row select: NeuronSel=3 -> WeightAddr 12,13,14,15; NeuronSel=10 with Start -> ignored, Busy stays 0.
REQ-039 Start while Busy and back-to-back: Start held high throughout -> ignored while Busy, second run accepted in the Done cycle, AccOut cleared, second Done exactly 7 cycles later.
REQ-040 Reset mid-run: GlobalReset pulsed at E3 -> all outputs 0 immediately and no Done; a subsequent Start yields the correct sum.
REQ-041 Sweep: MULT_LAT=3 -> Done at E(N_PIX+4) with the same AccOut as MULT_LAT=1.

Source files
------------

// File: rtl/neuron_mac_scheduler.sv
// neuron_mac_scheduler: sequences pixel/weight fetches for one neuron dot product and accumulates
// the multiplier results through a valid shift register matched to the multiplier latency.
module neuron_mac_scheduler #(
    parameter int N_PIX    = 784,
    parameter int N_NEURON = 10,
    parameter int MULT_LAT = 1
) (
    input  logic        clk,
    input  logic        GlobalReset,
    input  logic        Start,
    input  logic [3:0]  NeuronSel,
    output logic [9:0]  PixAddr,
    output logic [13:0] WeightAddr,
    input  logic [9:0]  PixelIn,
    input  logic [18:0] WeightIn,
    output logic [18:0] WeightPort,
    output logic [9:0]  PixelPort,
    input  logic [25:0] ProductIn,
    output logic [35:0] AccOut,
    output logic        Busy,
    output logic        Done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state_q, state_d;
    logic [9:0]        idx_q, idx_d;
    logic [13:0]       wa_q, wa_d;
    logic [MULT_LAT:0] vld_q, vld_d;
    logic [18:0]       wp_q, wp_d;
    logic [9:0]        pp_q, pp_d;
    logic [35:0]       acc_q, acc_d;
    logic              done_q, done_d;
    logic              accept, issue, last, final_add;
    // vld_q[0]: memory data valid, vld_q[1]: operands valid, vld_q[MULT_LAT]: product valid
    always_comb begin
        accept    = state_q == IDLE && Start && {28'd0, NeuronSel} < 32'(N_NEURON);
        issue     = state_q == ISSUE;
        last      = idx_q == 10'(N_PIX - 1);
        final_add = state_q == DRAIN && vld_q[MULT_LAT] && vld_q[MULT_LAT-1:0] == '0;
        state_d   = accept ? ISSUE : (issue && last) ? DRAIN : final_add ? IDLE : state_q;
        idx_d     = (issue && !last) ? idx_q + 10'd1 : '0;
        wa_d      = accept ? 14'(NeuronSel) * 14'(N_PIX) : (issue && !last) ? wa_q + 14'd1 : '0;
        vld_d     = {vld_q[MULT_LAT-1:0], issue};
        wp_d      = vld_q[0] ? WeightIn : '0;
        pp_d      = vld_q[0] ? PixelIn : '0;
        acc_d     = accept ? '0 : vld_q[MULT_LAT] ? acc_q + {{10{ProductIn[25]}}, ProductIn} : acc_q;
        done_d    = final_add;
    end
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wa_q    <= '0;
            vld_q   <= '0;
            wp_q    <= '0;
            pp_q    <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wa_q    <= wa_d;
            vld_q   <= vld_d;
            wp_q    <= wp_d;
            pp_q    <= pp_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end
    assign PixAddr    = idx_q;
    assign WeightAddr = wa_q;
    assign WeightPort = wp_q;
    assign PixelPort  = pp_q;
    assign AccOut     = acc_q;
    assign Busy       = state_q != IDLE;
    assign Done       = done_q;
endmodule

// File: tb/tb_neuron_mac_scheduler.sv
// tb_neuron_mac_scheduler: directed vectors against two instances (MULT_LAT 1 and 3) with
// synchronous memory and multiplier models.
module tb_neuron_mac_scheduler;
    logic        clk = 1'b0, GlobalReset = 1'b1, Start = 1'b0;
    logic [3:0]  NeuronSel = '0;
    logic [9:0]  pa1, pa3, pin1, pin3, pp1, pp3;
    logic [13:0] wa1, wa3;
    logic [18:0] win1, win3, wp1, wp3;
    logic [25:0] prod1, prod3, p3a, p3b;
    logic [28:0] f1, f3;
    logic [35:0] acc1, acc3;
    logic        busy1, busy3, done1, done3;
    logic [9:0]  pix_mem [16];
    logic [18:0] w_mem [64];
    int total = 0, bad = 0;

    typedef struct {
        logic [3:0]        sel;
        logic [0:3][9:0]   pix;
        logic [0:3][18:0]  w;
        logic [35:0]       exp;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    neuron_mac_scheduler #(.N_PIX(4), .N_NEURON(10), .MULT_LAT(1)) dut1 (
        .clk(clk), .GlobalReset(GlobalReset), .Start(Start), .NeuronSel(NeuronSel),
        .PixAddr(pa1), .WeightAddr(wa1), .PixelIn(pin1), .WeightIn(win1),
        .WeightPort(wp1), .PixelPort(pp1), .ProductIn(prod1), .AccOut(acc1),
        .Busy(busy1), .Done(done1));
    neuron_mac_scheduler #(.N_PIX(4), .N_NEURON(10), .MULT_LAT(3)) dut3 (
        .clk(clk), .GlobalReset(GlobalReset), .Start(Start), .NeuronSel(NeuronSel),
        .PixAddr(pa3), .WeightAddr(wa3), .PixelIn(pin3), .WeightIn(win3),
        .WeightPort(wp3), .PixelPort(pp3), .ProductIn(prod3), .AccOut(acc3),
        .Busy(busy3), .Done(done3));

    // signed weight times unsigned pixel, low 26 bits
    assign f1    = {{10{wp1[18]}}, wp1} * {19'd0, pp1};
    assign f3    = {{10{wp3[18]}}, wp3} * {19'd0, pp3};
    assign prod1 = f1[25:0];
    assign prod3 = p3b;
    always @(posedge clk) begin
        pin1 <= pix_mem[pa1[3:0]];
        win1 <= w_mem[wa1[5:0]];
        pin3 <= pix_mem[pa3[3:0]];
        win3 <= w_mem[wa3[5:0]];
        p3a  <= f3[25:0];
        p3b  <= p3a;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic load(input int i);
        for (int k = 0; k < 4; k++) begin
            pix_mem[k] = tbl[i].pix[k];
            w_mem[tbl[i].sel * 4 + k] = tbl[i].w[k];
        end
    endtask

    task automatic run_vec(input int i);
        int d1 = -1, d3 = -1, n1 = 0, n3 = 0;
        logic [35:0] a1 = '0, a3 = '0;
        load(i);
        @(negedge clk);
        Start = 1'b1;
        NeuronSel = tbl[i].sel;
        @(posedge clk);
        #1;
        Start = 1'b0;
        NeuronSel = tbl[i].sel ^ 4'h5;
        chk("busy_e0", busy1, 1);
        chk("acc_clr", acc1, 0);
        for (int k = 0; k < 4; k++) begin
            chk("pix_addr", pa1, k);
            chk("w_addr", wa1, tbl[i].sel * 4 + k);
            @(posedge clk);
            #1;
        end
        for (int c = 4; c <= 10; c++) begin
            if (done1) begin n1++; if (d1 < 0) begin d1 = c; a1 = acc1; end end
            if (done3) begin n3++; if (d3 < 0) begin d3 = c; a3 = acc3; end end
            @(posedge clk);
            #1;
        end
        chk("done_lat1", d1, 6);
        chk("acc1", a1, tbl[i].exp);
        chk("pulses1", n1, 1);
        chk("done_lat3", d3, 8);
        chk("acc3", a3, tbl[i].exp);
        chk("pulses3", n3, 1);
        chk("acc_hold", acc1, tbl[i].exp);
        chk("idle_busy", busy1, 0);
        chk("idle_addr", {pa1, wa1}, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int first, second, n;
        logic [35:0] a6, a7, a13;
        logic b7;
        for (int k = 0; k < 16; k++) pix_mem[k] = '0;
        for (int k = 0; k < 64; k++) w_mem[k] = '0;
        tbl[0] = '{4'd0, {10'd1, 10'd2, 10'd3, 10'd4}, {19'd10, 19'd20, 19'd30, 19'd40}, 36'd300};
        tbl[1] = '{4'd1, {10'd8, 10'd8, 10'd8, 10'd8}, {-19'sd5, -19'sd5, -19'sd5, -19'sd5}, 36'hFFFFFFF60};
        tbl[2] = '{4'd3, {10'd1, 10'd1, 10'd1, 10'd1}, {19'd1, 19'd2, 19'd3, 19'd4}, 36'd10};
        tbl[3] = '{4'd9, {10'd1023, 10'd1023, 10'd1023, 10'd1023},
                   {-19'sd32768, -19'sd32768, -19'sd32768, -19'sd32768}, -36'sd134086656};
        tbl[4] = '{4'd2, {10'd5, 10'd0, 10'd7, 10'd1}, {19'd3, -19'sd4, -19'sd2, 19'd100}, 36'd101};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {pa1, wa1, wp1, pp1, acc1, busy1, done1}, 0);
        @(negedge clk);
        GlobalReset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_busy", busy1, 0);

        for (int i = 0; i < 5; i++) run_vec(i);

        for (int s = 10; s < 16; s += 5) begin
            @(negedge clk);
            Start = 1'b1;
            NeuronSel = 4'(s);
            repeat (3) @(posedge clk);
            #1;
            chk("bad_sel_busy", {busy1, busy3}, 0);
            chk("bad_sel_addr", {pa1, wa1}, 0);
        end
        Start = 1'b0;

        load(0);
        first = -1; second = -1;
        a6 = '0; a7 = '1; a13 = '0; b7 = 1'b0;
        @(negedge clk);
        Start = 1'b1;
        NeuronSel = 4'd0;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (done1) begin if (first < 0) first = c; else if (second < 0) second = c; end
            if (c == 6) a6 = acc1;
            if (c == 7) begin a7 = acc1; b7 = busy1; end
            if (c == 13) a13 = acc1;
        end
        Start = 1'b0;
        chk("b2b_done1", first, 6);
        chk("b2b_acc1", a6, 300);
        chk("b2b_busy", b7, 1);
        chk("b2b_clr", a7, 0);
        chk("b2b_done2", second, 13);
        chk("b2b_acc2", a13, 300);
        repeat (20) @(posedge clk);

        @(negedge clk);
        Start = 1'b1;
        NeuronSel = 4'd0;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        GlobalReset = 1'b1;
        #1;
        chk("mid_rst_outs", {pa1, wa1, wp1, pp1, acc1, busy1, done1}, 0);
        chk("mid_rst_busy3", busy3, 0);
        @(negedge clk);
        @(negedge clk);
        GlobalReset = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done1 || done3) n++;
        end
        chk("mid_rst_nodone", n, 0);
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
